// File: rtl/dispense_scheduler.sv
// Dispense scheduler: round-robin grant of hand-present requests to a single servo that is
// driven through an extend/retract cycle with a periodically resent PWM pulse.
module dispense_scheduler #(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned EXT_US    = 700,
    parameter int unsigned RET_US    = 1500,
    parameter int unsigned TRAVEL_US = 250000,
    parameter int unsigned PERIOD_US = 16384
) (
    input  logic            clk_50m,
    input  logic            rst_n,
    input  logic            tick_1m,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            servo,
    output logic            busy,
    output logic            done
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PerW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam int unsigned TrvW = 18;
    localparam int unsigned PwW  = 11;

    localparam logic [TrvW-1:0] TravelLoad = TrvW'(TRAVEL_US - 1);
    localparam logic [PerW-1:0] PeriodLast = PerW'(PERIOD_US - 1);
    localparam logic [PwW-1:0]  ExtWidth   = PwW'(EXT_US);
    localparam logic [PwW-1:0]  RetWidth   = PwW'(RET_US);
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NREQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StExtend,
        StRetract
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] armed_q, armed_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [TrvW-1:0] travel_q, travel_d;
    logic [PerW-1:0] period_q, period_d;
    logic [PwW-1:0]  pulse_q, pulse_d;
    logic            servo_q, servo_d;
    logic            done_q, done_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] win_onehot;
    logic [IdxW-1:0] win_idx;
    logic            win_found;
    logic            busy_w;
    int unsigned     cand;

    assign busy_w = (state_q != StIdle);

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        eligible   = req & armed_q;
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        cand       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 32'(last_q) + 32'd1 + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_found && eligible[cand[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IdxW-1:0];
            end
        end
        win_onehot[win_idx] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        armed_d  = armed_q;
        last_d   = last_q;
        travel_d = travel_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                // Re-arm only once the hand has been withdrawn while idle.
                armed_d = armed_q | ~req;
                if (win_found) begin
                    state_d          = StExtend;
                    gnt_d            = win_onehot;
                    armed_d[win_idx] = 1'b0;
                    last_d           = win_idx;
                    travel_d         = TravelLoad;
                end
            end
            StExtend: begin
                if (tick_1m) begin
                    if (travel_q == '0) begin
                        state_d  = StRetract;
                        travel_d = TravelLoad;
                    end else begin
                        travel_d = travel_q - TrvW'(1);
                    end
                end
            end
            StRetract: begin
                if (tick_1m) begin
                    if (travel_q == '0) begin
                        state_d = StIdle;
                        gnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        travel_d = travel_q - TrvW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // PWM: a pulse in flight always runs to its latched width, regardless of state.
    always_comb begin
        period_d = period_q;
        pulse_d  = pulse_q;
        servo_d  = servo_q;
        if (tick_1m) begin
            period_d = (period_q == PeriodLast) ? '0 : period_q + PerW'(1);
            pulse_d  = (pulse_q != '0) ? pulse_q - PwW'(1) : '0;
            if ((period_q == '0) && busy_w && (pulse_d == '0)) begin
                pulse_d = (state_q == StExtend) ? ExtWidth : RetWidth;
            end
            servo_d = (pulse_d != '0);
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            armed_q  <= '1;
            last_q   <= LastIdx;
            travel_q <= '0;
            period_q <= '0;
            pulse_q  <= '0;
            servo_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            armed_q  <= armed_d;
            last_q   <= last_d;
            travel_q <= travel_d;
            period_q <= period_d;
            pulse_q  <= pulse_d;
            servo_q  <= servo_d;
            done_q   <= done_d;
        end
    end

    assign gnt   = gnt_q;
    assign servo = servo_q;
    assign busy  = busy_w;
    assign done  = done_q;

    a_gnt_onehot : assert property (@(posedge clk_50m) disable iff (!rst_n) $onehot0(gnt_q));
    a_gnt_busy   : assert property (@(posedge clk_50m) disable iff (!rst_n)
                                    busy_w == (gnt_q != '0));

endmodule

// File: tb/tb_dispense_scheduler.sv
// Bench for dispense_scheduler: directed scenarios plus randomized traffic, all checked
// against a tick-indexed reference model.
module tb_dispense_scheduler;

    localparam int NREQ   = 2;
    localparam int EXT    = 5;
    localparam int RET    = 9;
    localparam int TRAVEL = 40;
    localparam int PERIOD = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            tick_1m;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            servo;
    logic            busy;
    logic            done;

    int n_checks = 0;
    int n_errors = 0;

    dispense_scheduler #(
        .NREQ     (NREQ),
        .EXT_US   (EXT),
        .RET_US   (RET),
        .TRAVEL_US(TRAVEL),
        .PERIOD_US(PERIOD)
    ) dut (
        .clk_50m(clk),
        .rst_n  (rst_n),
        .tick_1m(tick_1m),
        .req    (req),
        .gnt    (gnt),
        .servo  (servo),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Reference model: phases measured in ticks, pulses tracked by absolute tick index.
    int              m_state;  // 0 idle, 1 extend, 2 retract
    int              m_phase;
    int              m_ticks;
    int              m_last;
    int              m_pstart;
    int              m_pw;
    bit              m_pvalid;
    logic [NREQ-1:0] m_armed;
    logic [NREQ-1:0] m_gnt;
    logic            m_done;

    function automatic logic m_servo();
        return m_pvalid && ((m_ticks - m_pstart) <= m_pw);
    endfunction

    task automatic model_edge();
        int  k;
        int  idx;
        int  sel;
        bit  found;
        bit  busy_pre;
        if (!rst_n) begin
            m_state = 0; m_phase = 0; m_ticks = 0; m_last = NREQ - 1;
            m_pvalid = 0; m_pstart = 0; m_pw = 0;
            m_armed = '1; m_gnt = '0; m_done = 0;
            return;
        end
        busy_pre = (m_state != 0);
        m_done   = 0;
        if (tick_1m) begin
            k = m_ticks;
            if ((k % PERIOD == 0) && busy_pre &&
                !(m_pvalid && (k + 1 - m_pstart <= m_pw))) begin
                m_pvalid = 1;
                m_pstart = k;
                m_pw     = (m_state == 1) ? EXT : RET;
            end
            m_ticks++;
        end
        case (m_state)
            0: begin
                found = 0;
                sel   = 0;
                for (int j = 1; j <= NREQ; j++) begin
                    idx = (m_last + j) % NREQ;
                    if (!found && req[idx] && m_armed[idx]) begin
                        found = 1;
                        sel   = idx;
                    end
                end
                for (int i = 0; i < NREQ; i++) if (!req[i]) m_armed[i] = 1'b1;
                if (found) begin
                    m_armed[sel] = 1'b0;
                    m_gnt        = '0;
                    m_gnt[sel]   = 1'b1;
                    m_last       = sel;
                    m_state      = 1;
                    m_phase      = 0;
                end
            end
            default: begin
                if (tick_1m) begin
                    m_phase++;
                    if (m_phase == TRAVEL) begin
                        m_phase = 0;
                        if (m_state == 1) begin
                            m_state = 2;
                        end else begin
                            m_state = 0;
                            m_gnt   = '0;
                            m_done  = 1;
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic step(input logic t, input logic [NREQ-1:0] r, input logic rn);
        tick_1m = t;
        req     = r;
        rst_n   = rn;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b11, 1'b0);
            n_checks++;
            if ({gnt, servo, busy, done} !== 5'b0) begin
                n_errors++;
                $display("FAIL reset_outputs gnt=%b servo=%b busy=%b done=%b want all 0",
                         gnt, servo, busy, done);
            end
        end
    endtask

    task automatic test_single_dispense();
        int q_w[$];
        int exp_w[5] = '{5, 5, 5, 9, 9};
        int run = 0;
        int busy_cyc = 0;
        int n_done = 0;
        int guard = 0;
        bit bad_w;
        step(1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 2'b00, 1'b1);
        step(1'b1, 2'b01, 1'b1);
        n_checks++;
        if (gnt !== 2'b01 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_grant gnt=%b busy=%b want gnt=01 busy=1", gnt, busy);
        end
        busy_cyc = 1;
        while (n_done == 0 && guard < 300) begin
            step(1'b1, 2'b01, 1'b1);
            guard++;
            n_checks++;
            if ({gnt, servo, busy, done} !== {m_gnt, m_servo(), m_state != 0, m_done}) begin
                n_errors++;
                $display("FAIL single_model t=%0t got %b/%b/%b/%b want %b/%b/%b/%b", $time,
                         gnt, servo, busy, done, m_gnt, m_servo(), m_state != 0, m_done);
            end
            if (busy) busy_cyc++;
            if (done) n_done++;
            if (servo) run++;
            else if (run != 0) begin q_w.push_back(run); run = 0; end
        end
        n_checks++;
        if (busy_cyc != 2 * TRAVEL || gnt !== 2'b00 || n_done != 1) begin
            n_errors++;
            $display("FAIL single_duration busy_cycles=%0d gnt=%b dones=%0d want %0d/00/1",
                     busy_cyc, gnt, n_done, 2 * TRAVEL);
        end
        bad_w = (q_w.size() != 5);
        if (!bad_w) for (int i = 0; i < 5; i++) if (q_w[i] != exp_w[i]) bad_w = 1;
        n_checks++;
        if (bad_w) begin
            n_errors++;
            $display("FAIL pulse_widths got %0d pulses (first %0d) want 5,5,5,9,9",
                     q_w.size(), (q_w.size() > 0) ? q_w[0] : -1);
        end
    endtask

    task automatic test_hold_hand();
        int busy_seen = 0;
        int guard = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 2'b01, 1'b1);
            if (busy) busy_seen++;
        end
        n_checks++;
        if (busy_seen != 0) begin
            n_errors++;
            $display("FAIL hold_no_retrigger busy_cycles=%0d want 0", busy_seen);
        end
        step(1'b1, 2'b00, 1'b1);
        step(1'b1, 2'b01, 1'b1);
        n_checks++;
        if (gnt !== 2'b01) begin
            n_errors++;
            $display("FAIL hold_rearm gnt=%b want 01", gnt);
        end
        while (!done && guard < 300) begin
            step(1'b1, 2'b01, 1'b1);
            guard++;
            n_checks++;
            if ({gnt, servo, busy, done} !== {m_gnt, m_servo(), m_state != 0, m_done}) begin
                n_errors++;
                $display("FAIL hold_model t=%0t got %b/%b/%b/%b want %b/%b/%b/%b", $time,
                         gnt, servo, busy, done, m_gnt, m_servo(), m_state != 0, m_done);
            end
        end
    endtask

    task automatic test_tick_gating();
        int   busy_ticks = 0;
        int   frozen_bad = 0;
        int   guard = 0;
        logic hold_servo;
        logic was_busy;
        step(1'b1, 2'b00, 1'b1);
        step(1'b1, 2'b01, 1'b1);
        for (int i = 0; i < 10; i++) begin
            was_busy = busy;
            step(1'b1, 2'b01, 1'b1);
            if (was_busy) busy_ticks++;
        end
        hold_servo = servo;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, 2'b01, 1'b1);
            if (servo !== hold_servo || !busy || done) frozen_bad++;
            n_checks++;
            if ({gnt, servo, busy, done} !== {m_gnt, m_servo(), m_state != 0, m_done}) begin
                n_errors++;
                $display("FAIL gating_model t=%0t got %b/%b/%b/%b want %b/%b/%b/%b", $time,
                         gnt, servo, busy, done, m_gnt, m_servo(), m_state != 0, m_done);
            end
        end
        n_checks++;
        if (frozen_bad != 0) begin
            n_errors++;
            $display("FAIL gating_freeze bad_cycles=%0d want 0", frozen_bad);
        end
        while (!done && guard < 300) begin
            was_busy = busy;
            step(1'b1, 2'b01, 1'b1);
            guard++;
            if (was_busy) busy_ticks++;
        end
        n_checks++;
        if (busy_ticks != 2 * TRAVEL || !done) begin
            n_errors++;
            $display("FAIL gating_travel busy_ticks=%0d done=%b want %0d/1",
                     busy_ticks, done, 2 * TRAVEL);
        end
    endtask

    task automatic test_simultaneous();
        int guard = 0;
        step(1'b0, 2'b11, 1'b0);
        step(1'b1, 2'b11, 1'b1);
        n_checks++;
        if (gnt !== 2'b01) begin
            n_errors++;
            $display("FAIL tie_first gnt=%b want 01", gnt);
        end
        while (!done && guard < 300) begin step(1'b1, 2'b11, 1'b1); guard++; end
        step(1'b1, 2'b11, 1'b1);
        n_checks++;
        if (gnt !== 2'b10) begin
            n_errors++;
            $display("FAIL tie_second gnt=%b want 10", gnt);
        end
        guard = 0;
        while (!done && guard < 300) begin
            step(1'b1, 2'b11, 1'b1);
            guard++;
            n_checks++;
            if ({gnt, servo, busy, done} !== {m_gnt, m_servo(), m_state != 0, m_done}) begin
                n_errors++;
                $display("FAIL tie_model t=%0t got %b/%b/%b/%b want %b/%b/%b/%b", $time,
                         gnt, servo, busy, done, m_gnt, m_servo(), m_state != 0, m_done);
            end
        end
        step(1'b1, 2'b00, 1'b1);
        step(1'b1, 2'b11, 1'b1);
        n_checks++;
        if (gnt !== 2'b01) begin
            n_errors++;
            $display("FAIL tie_rotate gnt=%b want 01", gnt);
        end
    endtask

    task automatic test_reset_mid_retract();
        int guard = 0;
        step(1'b0, 2'b01, 1'b0);
        step(1'b1, 2'b01, 1'b1);
        while (!(m_state == 2 && servo) && guard < 300) begin
            step(1'b1, 2'b01, 1'b1);
            guard++;
        end
        n_checks++;
        if (!(servo && busy)) begin
            n_errors++;
            $display("FAIL retract_pulse_reached servo=%b busy=%b want 1/1", servo, busy);
        end
        step(1'b1, 2'b01, 1'b0);
        n_checks++;
        if ({gnt, servo, busy, done} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_abort gnt=%b servo=%b busy=%b done=%b want all 0",
                     gnt, servo, busy, done);
        end
        step(1'b1, 2'b01, 1'b1);
        n_checks++;
        if (gnt !== 2'b01 || !busy) begin
            n_errors++;
            $display("FAIL reset_rearmed gnt=%b busy=%b want 01/1", gnt, busy);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] r = '0;
        logic            t;
        logic            rn;
        for (int i = 0; i < 6000; i++) begin
            for (int b = 0; b < NREQ; b++) if ($urandom_range(0, 29) == 0) r[b] = ~r[b];
            t  = ($urandom_range(0, 2) != 0);
            rn = ($urandom_range(0, 999) != 0);
            step(t, r, rn);
            n_checks++;
            if ({gnt, servo, busy, done} !== {m_gnt, m_servo(), m_state != 0, m_done}) begin
                n_errors++;
                $display("FAIL random_model t=%0t got %b/%b/%b/%b want %b/%b/%b/%b", $time,
                         gnt, servo, busy, done, m_gnt, m_servo(), m_state != 0, m_done);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        tick_1m = 1'b0;
        req     = '0;
        test_reset();
        test_single_dispense();
        test_hold_hand();
        test_tick_gating();
        test_simultaneous();
        test_reset_mid_retract();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
